// File: rtl/mc_pi_estimate.sv
// Fixed-point Monte Carlo pi estimator: est_pi = 4*pi_yes/(pi_yes+pi_no) via a bit-serial restoring divider.
// Define MC_PI_ROUND_EN to compute one extra quotient bit and round est_pi to nearest instead of truncating.
module mc_pi_estimate #(
    parameter int FRAC_BITS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        finish,
    input  logic [31:0] pi_yes,
    input  logic [31:0] pi_no,
    output logic [31:0] est_pi,
    output logic [32:0] est_total,
    output logic        div_zero,
    output logic        est_valid,
    input  logic        est_ready,
    output logic        busy
);

`ifdef MC_PI_ROUND_EN
    localparam int SHIFT = FRAC_BITS + 1;
`else
    localparam int SHIFT = FRAC_BITS;
`endif
    // Quotient register width equals dividend width: 4*pi_yes (34 bits) shifted by SHIFT.
    localparam int QW = 34 + SHIFT;
    localparam int CW = $clog2(QW);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DIV,
        DONE
    } state_t;

    state_t state, state_next;

    logic          finish_q;
    logic          finish_rise;
    logic [31:0]   yes_r;
    logic [31:0]   no_r;
    logic [32:0]   total;
    logic [32:0]   divisor;
    logic [32:0]   rem;
    logic [QW-1:0] work;
    logic [CW-1:0] count;

    logic [33:0]   rem_shift;
    logic [33:0]   rem_diff;
    logic          rem_ge;
    logic [32:0]   rem_next;
    logic [QW-1:0] work_next;
    logic [31:0]   quot_final;
    logic          unused_rem_msb;

    assign finish_rise = finish & ~finish_q;
    assign total       = {1'b0, yes_r} + {1'b0, no_r};

    // One restoring-division step: shift in the next dividend bit, subtract when it fits.
    // The remainder stays below the divisor (< 2^33), so the kept 33 bits are exact.
    assign rem_shift      = {rem, work[QW-1]};
    assign rem_diff       = rem_shift - {1'b0, divisor};
    assign rem_ge         = (rem_shift >= {1'b0, divisor});
    assign rem_next       = rem_ge ? rem_diff[32:0] : rem_shift[32:0];
    assign work_next      = {work[QW-2:0], rem_ge};
    assign unused_rem_msb = rem_diff[33];

`ifdef MC_PI_ROUND_EN
    assign quot_final = work_next[32:1] + {31'd0, work_next[0]};
`else
    assign quot_final = work_next[31:0];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        busy       = (state != IDLE);
        est_valid  = (state == DONE);
        case (state)
            IDLE: if (finish_rise) state_next = LOAD;
            LOAD: state_next = (total == 33'd0) ? DONE : DIV;
            DIV:  if (count == '0) state_next = DONE;
            DONE: if (est_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            finish_q  <= 1'b0;
            yes_r     <= '0;
            no_r      <= '0;
            divisor   <= '0;
            rem       <= '0;
            work      <= '0;
            count     <= '0;
            est_pi    <= '0;
            est_total <= '0;
            div_zero  <= 1'b0;
        end else begin
            finish_q <= finish;
            case (state)
                IDLE: begin
                    if (finish_rise) begin
                        yes_r <= pi_yes;
                        no_r  <= pi_no;
                    end
                end
                LOAD: begin
                    est_total <= total;
                    est_pi    <= '0;
                    if (total == 33'd0) begin
                        div_zero <= 1'b1;
                    end else begin
                        work    <= {yes_r, 2'b00, {SHIFT{1'b0}}};
                        divisor <= total;
                        rem     <= '0;
                        count   <= CW'(QW - 1);
                    end
                end
                DIV: begin
                    rem   <= rem_next;
                    work  <= work_next;
                    count <= count - 1'b1;
                    if (count == '0) est_pi <= quot_final;
                end
                DONE: begin
                    if (est_ready) div_zero <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_pi_estimate.sv
// Self-checking bench for mc_pi_estimate: directed and random runs against a plain-arithmetic division model.
module tb_mc_pi_estimate;
    localparam int F = 16;
`ifdef MC_PI_ROUND_EN
    localparam int LAT = 36 + F;
`else
    localparam int LAT = 35 + F;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        finish;
    logic [31:0] pi_yes;
    logic [31:0] pi_no;
    logic [31:0] est_pi;
    logic [32:0] est_total;
    logic        div_zero;
    logic        est_valid;
    logic        est_ready;
    logic        busy;

    mc_pi_estimate #(.FRAC_BITS(F)) dut (
        .clk       (clk),
        .rst       (rst),
        .finish    (finish),
        .pi_yes    (pi_yes),
        .pi_no     (pi_no),
        .est_pi    (est_pi),
        .est_total (est_total),
        .div_zero  (div_zero),
        .est_valid (est_valid),
        .est_ready (est_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic        exp_armed = 1'b0;
    logic [31:0] exp_pi;
    logic [32:0] exp_total;
    logic        exp_dz;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: exact rational 4*y/(y+n) scaled by 2^F, truncated or rounded half-up.
    function automatic logic [31:0] model_pi(input logic [31:0] y, input logic [31:0] n);
        longint unsigned tot, num, q;
        tot = longint'(y) + longint'(n);
        if (tot == 0) return 32'd0;
        num = longint'(y) * 4;
`ifdef MC_PI_ROUND_EN
        q = (num << (F + 1)) / tot;
        return 32'((q >> 1) + (q & 1));
`else
        q = (num << F) / tot;
        return 32'(q);
`endif
    endfunction

    // Every cycle a result is presented it must match the model; otherwise div_zero stays low.
    always @(negedge clk) begin
        if (!rst) begin
            if (est_valid) begin
                if (!exp_armed) begin
                    check("spurious_valid", 64'(est_valid), 64'd0);
                end else begin
                    check("est_pi", 64'(est_pi), 64'(exp_pi));
                    check("est_total", 64'(est_total), 64'(exp_total));
                    check("div_zero", 64'(div_zero), 64'(exp_dz));
                    check("busy_in_done", 64'(busy), 64'd1);
                end
            end else begin
                check("div_zero_idle", 64'(div_zero), 64'd0);
            end
        end
    end

    task automatic run(input logic [31:0] y, input logic [31:0] n, input int ready_wait,
                       input bit pulse, input bit use_lit, input logic [31:0] lit_pi,
                       input bit pre_high);
        int lat;
        bit found;
        exp_pi    = model_pi(y, n);
        exp_total = {1'b0, y} + {1'b0, n};
        exp_dz    = (exp_total == 33'd0);
        exp_armed = 1'b1;
        if (use_lit) check("model_pin", 64'(exp_pi), 64'(lit_pi));
        pi_yes    = y;
        pi_no     = n;
        est_ready = (ready_wait == 0);
        if (!pre_high) finish = 1'b1;
        @(posedge clk);
        lat   = 0;
        found = 1'b0;
        while (lat < 300 && !found) begin
            @(negedge clk);
            if (est_valid) begin
                found = 1'b1;
            end else begin
                if (lat == 1) begin
                    pi_yes = $urandom;
                    pi_no  = $urandom;
                end
                if (lat == 2) finish = 1'b0;
                if (pulse && lat == 5) finish = 1'b1;
                if (pulse && lat == 6) finish = 1'b0;
                @(posedge clk);
                lat++;
            end
        end
        finish = 1'b0;
        check("latency", 64'(lat), exp_dz ? 64'd1 : 64'(LAT));
        if (use_lit) check("lit_est_pi", 64'(est_pi), 64'(lit_pi));
        for (int i = 0; i < ready_wait; i++) begin
            if (pulse && i == 3) finish = 1'b1;
            if (pulse && i == 5) finish = 1'b0;
            @(negedge clk);
            check("hold_valid", 64'(est_valid), 64'd1);
        end
        finish    = 1'b0;
        est_ready = 1'b1;
        @(negedge clk);
        check("valid_drops", 64'(est_valid), 64'd0);
        check("busy_drops", 64'(busy), 64'd0);
        est_ready = 1'b0;
        exp_armed = 1'b0;
        repeat (5) @(negedge clk);
        check("no_requeue", 64'(busy), 64'd0);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_est_pi"}, 64'(est_pi), 64'd0);
        check({tag, "_est_total"}, 64'(est_total), 64'd0);
        check({tag, "_div_zero"}, 64'(div_zero), 64'd0);
        check({tag, "_est_valid"}, 64'(est_valid), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        logic [31:0] y, n;
        rst       = 1'b1;
        finish    = 1'b0;
        est_ready = 1'b0;
        pi_yes    = '0;
        pi_no     = '0;
        #3;
        check_zero_outputs("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run(32'd785, 32'd215, 0, 1'b0, 1'b1, 32'h000323D7, 1'b0);
`ifdef MC_PI_ROUND_EN
        run(32'd2, 32'd1, 0, 1'b0, 1'b1, 32'h0002AAAB, 1'b0);
`else
        run(32'd2, 32'd1, 0, 1'b0, 1'b1, 32'h0002AAAA, 1'b0);
`endif
        run(32'd0, 32'd0, 3, 1'b1, 1'b1, 32'h00000000, 1'b0);
        run(32'd5, 32'd0, 0, 1'b0, 1'b1, 32'h00040000, 1'b0);
        run(32'hFFFFFFFF, 32'd0, 2, 1'b0, 1'b1, 32'h00040000, 1'b0);
        run(32'hFFFFFFFF, 32'hFFFFFFFF, 1, 1'b0, 1'b1, 32'h00020000, 1'b0);
        run(32'd785, 32'd215, 10, 1'b1, 1'b1, 32'h000323D7, 1'b0);

        // Reset in the middle of a division: outputs clear at once, the result never appears.
        exp_pi    = model_pi(32'd785, 32'd215);
        exp_total = 33'd1000;
        exp_dz    = 1'b0;
        exp_armed = 1'b1;
        pi_yes    = 32'd785;
        pi_no     = 32'd215;
        finish    = 1'b1;
        @(posedge clk);
        repeat (20) @(posedge clk);
        #2;
        check("mid_div_total", 64'(est_total), 64'd1000);
        rst = 1'b1;
        #1;
        check_zero_outputs("async_rst");
        exp_armed = 1'b0;
        finish    = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (60) @(negedge clk);
        check("post_rst_idle", 64'(busy), 64'd0);

        // finish already high when reset releases counts as an edge on the first clock.
        rst    = 1'b1;
        finish = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        run(32'd3, 32'd1, 0, 1'b0, 1'b1, 32'h00030000, 1'b1);

        for (int k = 0; k < 20; k++) begin
            case (k % 4)
                0: begin y = $urandom; n = $urandom; end
                1: begin y = $urandom & 32'hFFFF; n = $urandom & 32'hFF; end
                2: begin y = $urandom & 32'hFF; n = $urandom; end
                default: begin y = $urandom_range(0, 3); n = $urandom_range(0, 3); end
            endcase
            run(y, n, $urandom_range(0, 4), 1'($urandom_range(0, 1)), 1'b0, 32'd0, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mc_pi_estimate.md
MC_PI_ESTIMATE -- requirements
Module: mc_pi_estimate

Interface
REQ-001 Parameter FRAC_BITS, default 16: fractional bits of the fixed-point estimate, legal range 8..28.
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 finish  in  1  level from the sampling stage; a rising edge means a run has completed.
REQ-005 pi_yes  in  32  count of points inside the quarter circle.
REQ-006 pi_no  in  32  count of points outside the quarter circle.
REQ-007 est_pi  out  32  estimate 4*pi_yes/(pi_yes+pi_no), unsigned Q(32-FRAC_BITS).FRAC_BITS.
REQ-008 est_total  out  33  latched pi_yes+pi_no.
REQ-009 div_zero  out  1  high with est_valid when the latched total is 0.
REQ-010 est_valid  out  1  result-valid handshake output.
REQ-011 est_ready  in  1  consumer accept.
REQ-012 busy  out  1  high in every state except IDLE.

Function
REQ-013 States: IDLE, LOAD, DIV, DONE; the state register is the only FSM storage.
REQ-014 Rising edge of finish: detected from a registered copy of finish, so a level held high triggers once.
REQ-015 Trigger while in IDLE: latch pi_yes and pi_no, move to LOAD; call this edge E0.
REQ-016 Rising edges of finish seen outside IDLE: ignored, neither queued nor counted.
REQ-017 LOAD, total 0 (E1): go to DONE with est_pi=0 and div_zero=1.
REQ-018 LOAD, total non-zero (E1): load dividend (4*pi_yes)<<FRAC_BITS (34+FRAC_BITS bits, zero-extended), divisor = total, remainder 0, go to DIV.
REQ-019 DIV: restoring division, exactly one quotient bit per cycle, MSB first, for 34+FRAC_BITS cycles; go to DONE after the last bit.
REQ-020 Default latency: est_valid rises at edge E(35+FRAC_BITS), which is E51 for FRAC_BITS=16.
REQ-021 Quotient bound: the quotient is at most 4<<FRAC_BITS, so it fits in 32 bits; est_pi = quotient[31:0] with no saturation needed.
REQ-022 DONE: est_valid=1; est_pi, est_total and div_zero stay constant until the handshake.
REQ-023 Handshake: est_valid & est_ready sampled at an edge completes it; the next state is IDLE and est_valid=0 on the following cycle.
REQ-024 est_ready while est_valid is low: no effect.
REQ-025 est_total and est_pi: change only on the LOAD->DIV/DONE transition and at DIV completion; div_zero is cleared on leaving DONE.

Reset
REQ-026 rst asserted, any state: FSM goes to IDLE immediately without waiting for a clock.
REQ-027 Reset values: est_pi=0, est_total=0, div_zero=0, est_valid=0, busy=0; finish edge register=0.
REQ-028 Reset in the middle of a division: the result is discarded and never presented.
REQ-029 After reset release: finish already high while rst falls counts as an edge on the first clock.

Configuration
REQ-030 Macro MC_PI_ROUND_EN defined: DIV runs 35+FRAC_BITS cycles, producing one extra quotient bit, and est_pi = (quotient+extra bit) rounds to nearest; latency is E(36+FRAC_BITS).
REQ-031 Macro MC_PI_ROUND_EN undefined: est_pi is truncated, with the latency in REQ-020.

Verification
REQ-032 pi_yes=785, pi_no=215, finish rises, est_ready=1 -> est_total=1000, est_pi=0x000323D7 at E51; the same value with MC_PI_ROUND_EN at E52.
REQ-033 pi_yes=2, pi_no=1 -> est_pi=0x0002AAAA; with MC_PI_ROUND_EN, 0x0002AAAB.
REQ-034 pi_yes=0, pi_no=0 -> at E1: est_valid=1, div_zero=1, est_pi=0, est_total=0; pi_yes=5, pi_no=0 -> est_pi=0x00040000, div_zero=0.
REQ-035 est_ready held low for 10 cycles after est_valid, with a second finish pulse during that time -> outputs stay stable, the pulse is ignored, and exactly one handshake occurs.
REQ-036 rst pulsed at E20 of a division -> all outputs zero asynchronously, est_valid never asserts, and a new finish edge then gives a correct result.
